tx_link_scheduler: RTL and testbench
====================================

Name: tx_link_scheduler

Overview:
- Sequences the 8b/10b encoder on the optical TX path.
- Generates the encoder's one-word-per-slot strobe.
- Arbitrates between two byte-stream packet sources, round robin at packet boundaries.
- Frames each packet with a channel header byte and enforces a minimum comma gap between packets; fills unused slots with idle commas for receiver alignment.

Parameters:
WORD_CLKS, 10, clk cycles per encoded word slot (serialiser ratio); minimum 2
MIN_IDLE, 4, minimum idle commas sent between packets and after reset; minimum 1
MAX_LEN, 256, maximum payload bytes per packet before forced truncation
HDR_BASE, 8'hA0, header byte = HDR_BASE | channel index

Ports:
clk  in  1  system clock
rst  in  1  reset
s0_valid  in  1  source 0 byte valid
s0_data  in  8  source 0 byte
s0_last  in  1  source 0 final byte of packet
s0_ready  out  1  source 0 byte consumed this cycle
s1_valid  in  1  source 1 byte valid
s1_data  in  8  source 1 byte
s1_last  in  1  source 1 final byte of packet
s1_ready  out  1  source 1 byte consumed this cycle
enc_nextword  out  1  encoder load strobe (encoder nextword_enable)
enc_idle  out  1  encoder idle (comma) request
enc_data  out  8  encoder data byte
underrun  out  1  sticky: granted source not valid mid-packet
truncated  out  1  sticky: packet hit MAX_LEN without last

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk. All state is on posedge clk or posedge rst.
- Reset values:
  - Outputs: enc_nextword=0, enc_idle=1, enc_data=0, s*_ready=0, underrun=0, truncated=0.
  - Internal: state=GAP, gap_cnt=0, len_cnt=0, last_grant=1 (channel 0 wins first).
- Slot timer:
  - cnt runs 0..WORD_CLKS-1 and wraps.
  - tick = (cnt==WORD_CLKS-1).
  - All scheduling decisions occur only on tick cycles.
- Output timing:
  - enc_data/enc_idle are registered on the tick cycle.
  - enc_nextword is tick delayed by one cycle, so it pulses for 1 cycle at T+1 with enc_data/enc_idle already stable.
  - enc_data/enc_idle hold until the next tick.
  - The first enc_nextword occurs WORD_CLKS cycles after rst deasserts.
- Source handshake:
  - sN_ready is combinational: tick && state==DATA && grant==N && len_cnt<MAX_LEN.
  - A byte transfers when valid && ready. Sources must hold data stable while valid.
  - A byte consumed at tick T appears on enc_data at T+1 with enc_nextword=1 (1-cycle latency).
- States, evaluated at tick:
  - GAP:
    - Emit comma (enc_idle=1); gap_cnt saturates at MIN_IDLE.
    - If gap_cnt>=MIN_IDLE and any sN_valid, go to ARB-decision in this same slot instead of the comma.
  - ARB-decision (same tick as leaving GAP):
    - grant = requester other than last_grant if it is valid, else the valid one.
    - Emit header HDR_BASE|grant with enc_idle=0.
    - len_cnt=0; go to DATA.
    - The header slot does not consume a source byte.
  - DATA:
    - If granted valid: emit byte, len_cnt+1.
      - If last: last_grant=grant, gap_cnt=0, go to GAP.
    - If granted not valid: emit comma, set underrun, stay in DATA. Packet is not aborted.
    - If len_cnt==MAX_LEN: ready stays low, emit comma, set truncated, last_grant=grant, gap_cnt=0, go to GAP. The source's remaining bytes start a new packet later.
- Gap counting: the comma emitted in the terminating GAP slot counts; exactly MIN_IDLE commas separate the last byte of one packet from the next header.
- Simultaneous events:
  - Both sources valid at arbitration: round robin as above.
  - A non-granted source's valid is ignored during DATA.
- Reset mid-packet: everything returns to reset values immediately. The packet is abandoned with no further output. After release, MIN_IDLE commas are sent before any header.
- Sticky flags clear only on rst.

Decomposition:
- Shared package/include holds:
  - state encodings GAP/DATA;
  - HDR_BASE default;
  - the channel-index width.
- The encoder comma constants stay where they are. This block only drives idle.
- One natural sub-module: word_slot_timer (cnt, tick, delayed strobe), reusable by the RX deserialiser timing.

Test Plan:
- Reset release, no sources valid: enc_nextword every 10 cycles, enc_idle=1 for every slot, flags 0.
- s0 sends 3-byte packet {11,22,33,last} after 4 commas: slots show A0,11,22,33 with enc_idle=0, then 4 commas. s0_ready pulses exactly 3 times, each on a tick.
- s0 and s1 both hold packets continuously:
  - headers alternate A0,A1,A0,...;
  - each header is preceded by exactly 4 commas.
- s1 drops valid for 2 slots mid-packet: 2 comma slots inside the packet, underrun=1, remaining bytes follow unchanged.
- MAX_LEN=4, s0 sends 6 bytes without last:
  - A0 + 4 bytes, then comma, truncated=1;
  - after 4 commas, A0 + remaining 2 bytes.
- rst asserted 3 cycles after a DATA tick: outputs at reset values within the same cycle; after release, 4 commas before the next header.

Source files
------------

// File: rtl/tx_link_scheduler_pkg.sv
// Shared definitions for the TX link scheduler: FSM encoding, header base, channel width.
package tx_link_scheduler_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
  localparam int         CH_W             = 1;

  typedef logic [CH_W-1:0] ch_t;

endpackage

// File: rtl/word_slot_timer.sv
// Word slot timer: free-running slot counter, decision tick, and the one-cycle-late load strobe.
module word_slot_timer #(
  parameter int unsigned WORD_CLKS = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic strobe
);

  localparam int unsigned CW = (WORD_CLKS > 1) ? $clog2(WORD_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_CLKS - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= tick;
      cnt    <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tx_link_scheduler.sv
// TX link scheduler: round-robin packet framing of two byte sources into 8b/10b encoder slots.
module tx_link_scheduler
  import tx_link_scheduler_pkg::*;
#(
  parameter int unsigned WORD_CLKS = 10,
  parameter int unsigned MIN_IDLE  = 4,
  parameter int unsigned MAX_LEN   = 256,
  parameter logic [7:0]  HDR_BASE  = HDR_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       enc_nextword,
  output logic       enc_idle,
  output logic [7:0] enc_data,
  output logic       underrun,
  output logic       truncated
);

  localparam int unsigned GW = $clog2(MIN_IDLE + 1);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam logic [GW-1:0] GAP_DONE = GW'(MIN_IDLE);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  logic tick;

  word_slot_timer #(.WORD_CLKS(WORD_CLKS)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .strobe (enc_nextword)
  );

  state_t        state, state_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [LW-1:0] len_cnt, len_n;
  ch_t           grant, grant_n;
  ch_t           last_grant, last_n;
  logic [7:0]    data_n;
  logic          idle_n, under_n, trunc_n;

  ch_t           pick;
  logic          g_valid, g_last;
  logic [7:0]    g_data;
  logic          room;

  assign room     = (len_cnt < LEN_MAX);
  assign s0_ready = tick && (state == DATA) && (grant == ch_t'(0)) && room;
  assign s1_ready = tick && (state == DATA) && (grant == ch_t'(1)) && room;

  assign g_valid = (grant == ch_t'(1)) ? s1_valid : s0_valid;
  assign g_data  = (grant == ch_t'(1)) ? s1_data  : s0_data;
  assign g_last  = (grant == ch_t'(1)) ? s1_last  : s0_last;

  // Prefer the channel that did not send last; fall back to whichever is valid.
  always_comb begin
    pick = ch_t'(0);
    if (last_grant == ch_t'(0)) pick = s1_valid ? ch_t'(1) : ch_t'(0);
    else                        pick = s0_valid ? ch_t'(0) : ch_t'(1);
  end

  // NOTE: every combinational output gets a hold default first so no path infers a latch.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    len_n   = len_cnt;
    grant_n = grant;
    last_n  = last_grant;
    data_n  = enc_data;
    idle_n  = enc_idle;
    under_n = underrun;
    trunc_n = truncated;
    if (tick) begin
      unique case (state)
        GAP: begin
          if ((gap_cnt >= GAP_DONE) && (s0_valid || s1_valid)) begin
            grant_n = pick;
            data_n  = HDR_BASE | 8'(pick);
            idle_n  = 1'b0;
            len_n   = '0;
            state_n = DATA;
          end else begin
            data_n = 8'h00;
            idle_n = 1'b1;
            if (gap_cnt < GAP_DONE) gap_n = gap_cnt + GW'(1);
          end
        end
        DATA: begin
          if (!room) begin
            data_n  = 8'h00;
            idle_n  = 1'b1;
            trunc_n = 1'b1;
            last_n  = grant;
            gap_n   = '0;
            state_n = GAP;
          end else if (g_valid) begin
            data_n = g_data;
            idle_n = 1'b0;
            len_n  = len_cnt + LW'(1);
            if (g_last) begin
              last_n  = grant;
              gap_n   = '0;
              state_n = GAP;
            end
          end else begin
            // Source stalled mid-packet: fill with a comma and keep the packet open.
            data_n  = 8'h00;
            idle_n  = 1'b1;
            under_n = 1'b1;
          end
        end
        default: state_n = GAP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GAP;
      gap_cnt    <= '0;
      len_cnt    <= '0;
      grant      <= ch_t'(0);
      last_grant <= ch_t'(1);
      enc_data   <= 8'h00;
      enc_idle   <= 1'b1;
      underrun   <= 1'b0;
      truncated  <= 1'b0;
    end else begin
      state      <= state_n;
      gap_cnt    <= gap_n;
      len_cnt    <= len_n;
      grant      <= grant_n;
      last_grant <= last_n;
      enc_data   <= data_n;
      enc_idle   <= idle_n;
      underrun   <= under_n;
      truncated  <= trunc_n;
    end
  end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed bench for tx_link_scheduler: slot-level scoreboard, source drivers, sticky flag checks.
module tb_tx_link_scheduler;

  localparam int WORD_CLKS = 10;
  localparam int MIN_IDLE  = 4;
  localparam int MAX_LEN   = 4;

  typedef struct packed {
    logic       idle;
    logic [7:0] data;
  } slot_t;

  logic       clk, rst;
  logic [1:0] vld, lst;
  logic [7:0] dat [2];
  logic       s0_ready, s1_ready;
  logic       enc_nextword, enc_idle;
  logic [7:0] enc_data;
  logic       underrun, truncated;

  int checks   = 0;
  int failures = 0;

  slot_t      sb [$];
  bit         sb_on = 0;
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int         sent [2], pause_left [2], pause_at [2], pause_len [2], rp [2];
  bit         pend_take [2], pend_pause [2];

  tx_link_scheduler #(
    .WORD_CLKS (WORD_CLKS),
    .MIN_IDLE  (MIN_IDLE),
    .MAX_LEN   (MAX_LEN),
    .HDR_BASE  (8'hA0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s0_valid     (vld[0]),
    .s0_data      (dat[0]),
    .s0_last      (lst[0]),
    .s0_ready     (s0_ready),
    .s1_valid     (vld[1]),
    .s1_data      (dat[1]),
    .s1_last      (lst[1]),
    .s1_ready     (s1_ready),
    .enc_nextword (enc_nextword),
    .enc_idle     (enc_idle),
    .enc_data     (enc_data),
    .underrun     (underrun),
    .truncated    (truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source model: a transfer seen at one falling edge is retired at the next one,
  // after the rising edge that consumed it, so data stays stable across that edge.
  task automatic src_step(input int n);
    logic       rdy;
    int         sz;
    logic [8:0] fr;
    rdy = (n == 0) ? s0_ready : s1_ready;
    if (rst) begin
      pend_take[n]  = 0;
      pend_pause[n] = 0;
      sent[n]       = 0;
      pause_left[n] = 0;
      rp[n]         = 0;
    end
    if (pend_take[n]) begin
      if (n == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      sent[n]++;
      if (sent[n] == pause_at[n]) pause_left[n] = pause_len[n];
    end
    if (pend_pause[n] && pause_left[n] > 0) pause_left[n]--;
    pend_take[n]  = 0;
    pend_pause[n] = 0;
    sz = (n == 0) ? q0.size() : q1.size();
    fr = 9'h000;
    if (sz > 0) fr = (n == 0) ? q0[0] : q1[0];
    vld[n] = (sz > 0) && (pause_left[n] == 0);
    dat[n] = fr[7:0];
    lst[n] = fr[8];
    if (rdy) begin
      rp[n]++;
      if (vld[n])                 pend_take[n]  = 1;
      else if (pause_left[n] > 0) pend_pause[n] = 1;
    end
  endtask

  initial begin
    vld = '0;
    lst = '0;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    forever begin
      @(negedge clk);
      src_step(0);
      src_step(1);
    end
  end

  // Slot monitor: checks strobe spacing and compares each loaded word to the scoreboard.
  initial begin
    int    since;
    slot_t e;
    since = 0;
    forever begin
      @(negedge clk);
      if (rst) since = 0;
      else begin
        since++;
        if (enc_nextword) begin
          check("slot_period", since, WORD_CLKS);
          since = 0;
          if (sb_on && sb.size() > 0) begin
            e = sb.pop_front();
            check("slot_idle", {31'd0, enc_idle}, {31'd0, e.idle});
            if (!e.idle) check("slot_data", {24'd0, enc_data}, {24'd0, e.data});
          end
        end
      end
    end
  end

  task automatic exp_comma(input int n);
    slot_t s;
    s.idle = 1'b1;
    s.data = 8'h00;
    repeat (n) sb.push_back(s);
  endtask

  task automatic exp_word(input logic [7:0] d);
    slot_t s;
    s.idle = 1'b0;
    s.data = d;
    sb.push_back(s);
  endtask

  task automatic load(input int n, input logic [7:0] d, input logic l);
    if (n == 0) q0.push_back({l, d});
    else        q1.push_back({l, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nextword"},  {31'd0, enc_nextword}, 32'd0);
    check({tag, "_idle"},      {31'd0, enc_idle},     32'd1);
    check({tag, "_data"},      {24'd0, enc_data},     32'd0);
    check({tag, "_s0_ready"},  {31'd0, s0_ready},     32'd0);
    check({tag, "_s1_ready"},  {31'd0, s1_ready},     32'd0);
    check({tag, "_underrun"},  {31'd0, underrun},     32'd0);
    check({tag, "_truncated"}, {31'd0, truncated},    32'd0);
  endtask

  task automatic begin_reset();
    @(negedge clk);
    #1;
    rst   = 1'b1;
    sb_on = 0;
    sb.delete();
    q0.delete();
    q1.delete();
    pause_at[0] = -1;
    pause_at[1] = -1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    sb_on = 1;
    rst   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, sb.size(), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    pause_at[0] = -1;
    pause_at[1] = -1;
    pause_len[0] = 0;
    pause_len[1] = 0;

    // Idle link after reset: commas only, flags clear.
    begin_reset();
    #1;
    check_reset_outputs("rst_init");
    exp_comma(6);
    release_reset();
    wait_drain("idle", 1000);
    check("idle_underrun", {31'd0, underrun}, 32'd0);
    check("idle_truncated", {31'd0, truncated}, 32'd0);

    // Single 3-byte packet from source 0.
    begin_reset();
    load(0, 8'h11, 0); load(0, 8'h22, 0); load(0, 8'h33, 1);
    exp_comma(4); exp_word(8'hA0); exp_word(8'h11); exp_word(8'h22); exp_word(8'h33); exp_comma(4);
    release_reset();
    wait_drain("pkt3", 1000);
    check("pkt3_s0_ready_pulses", rp[0], 32'd3);
    check("pkt3_s1_ready_pulses", rp[1], 32'd0);
    check("pkt3_underrun", {31'd0, underrun}, 32'd0);

    // Both sources busy: headers alternate, 4 commas before each.
    begin_reset();
    load(0, 8'h01, 0); load(0, 8'h02, 1); load(0, 8'h03, 0); load(0, 8'h04, 1);
    load(1, 8'h81, 0); load(1, 8'h82, 1); load(1, 8'h83, 0); load(1, 8'h84, 1);
    exp_comma(4); exp_word(8'hA0); exp_word(8'h01); exp_word(8'h02);
    exp_comma(4); exp_word(8'hA1); exp_word(8'h81); exp_word(8'h82);
    exp_comma(4); exp_word(8'hA0); exp_word(8'h03); exp_word(8'h04);
    exp_comma(4); exp_word(8'hA1); exp_word(8'h83); exp_word(8'h84);
    exp_comma(4);
    release_reset();
    wait_drain("rr", 2000);
    check("rr_underrun", {31'd0, underrun}, 32'd0);
    check("rr_truncated", {31'd0, truncated}, 32'd0);

    // Source 1 stalls for two slots mid-packet.
    begin_reset();
    load(1, 8'h91, 0); load(1, 8'h92, 0); load(1, 8'h93, 0); load(1, 8'h94, 1);
    pause_at[1]  = 2;
    pause_len[1] = 2;
    exp_comma(4); exp_word(8'hA1); exp_word(8'h91); exp_word(8'h92);
    exp_comma(2); exp_word(8'h93); exp_word(8'h94); exp_comma(4);
    release_reset();
    wait_drain("stall", 1500);
    check("stall_underrun", {31'd0, underrun}, 32'd1);
    check("stall_truncated", {31'd0, truncated}, 32'd0);
    pause_at[1] = -1;

    // Six bytes with no early last: cut at MAX_LEN, remainder framed as a new packet.
    begin_reset();
    load(0, 8'hB1, 0); load(0, 8'hB2, 0); load(0, 8'hB3, 0);
    load(0, 8'hB4, 0); load(0, 8'hB5, 0); load(0, 8'hB6, 1);
    exp_comma(4); exp_word(8'hA0);
    exp_word(8'hB1); exp_word(8'hB2); exp_word(8'hB3); exp_word(8'hB4);
    exp_comma(1); exp_comma(4);
    exp_word(8'hA0); exp_word(8'hB5); exp_word(8'hB6); exp_comma(4);
    release_reset();
    wait_drain("trunc", 2000);
    check("trunc_truncated", {31'd0, truncated}, 32'd1);
    check("trunc_underrun", {31'd0, underrun}, 32'd0);

    // Reset three cycles after a DATA tick; link restarts with 4 commas.
    sb_on = 0;
    load(0, 8'hC1, 0); load(0, 8'hC2, 0); load(0, 8'hC3, 1);
    k = 0;
    while (!s0_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("midrst_data_tick_seen", {31'd0, (k < 500)}, 32'd1);
    repeat (3) @(posedge clk);
    #2;
    rst   = 1'b1;
    sb.delete();
    q0.delete();
    q1.delete();
    #1;
    check_reset_outputs("midrst");
    load(0, 8'h5A, 1);
    exp_comma(4); exp_word(8'hA0); exp_word(8'h5A); exp_comma(4);
    release_reset();
    wait_drain("midrst", 1500);
    check("midrst_truncated", {31'd0, truncated}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
